vec_elem_sequencer: RTL and testbench

- Downstream consumer of the vector CSR register file outputs (vl, vstart, sew, vlmul, tail/mask agnostic).
- Per accepted vector instruction, walks element indices from vstart to vl-1 and issues one element micro-op per ready/valid handshake to the lane datapath.
- Reports register-group position, tail/mask-policy flags and completion.
- Pulses a vstart-clear request at the end so the CSR file returns vstart to 0.

---
 rtl/vec_elem_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_vec_elem_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_elem_sequencer.sv
// ---------------------------------------------------------------------------
// vec_elem_sequencer
//
// Purpose:
//   Walks the element indices of one accepted vector instruction, from
//   vstart up to vl-1, and hands them to the lane datapath one element
//   micro-op per ready/valid handshake. The sequencer also:
//     - reports the register-group position (register within the LMUL
//       group, element offset within that register),
//     - latches the tail/mask agnostic policy bits,
//     - pulses done and vstart_clr when the instruction finishes, so the
//       CSR file can return vstart to 0.
//
// Configuration:
//   VEC_TAIL_FILL_EN  When defined, the tail elements (vl_eff..vlmax-1) are
//                     issued with elem_tail=1 if the latched vta is 1, so the
//                     lane can write all-ones. When undefined, the TAIL state
//                     is unreachable and elem_tail is tied to 0.
//   XLEN              Width of the index/length buses (default 32).
//
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   instr_valid/ready   instruction handshake (ready only while idle)
//   vec_length          vl from the CSR file
//   start_element       vstart from the CSR file
//   sew                 element width in bits: 8/16/32/64, anything else is
//                       reserved. The bus is 7 bits wide so that 64 fits.
//   vlmul               group multiplier: 1/2/4/8
//   tail_agnostic       vta
//   mask_agnostic       vma
//   elem_valid/ready    element micro-op handshake
//   elem_idx            absolute element index
//   elem_reg            register offset within the LMUL group
//   elem_off            element offset within that register
//   elem_tail           element lies in the tail (idx >= vl_eff)
//   elem_ma             latched vma
//   busy                instruction in progress
//   done, vstart_clr    one-cycle completion pulses (coincident)
//   cfg_err             reserved sew / illegal vlmul, sticky until next accept
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module vec_elem_sequencer #(
  parameter  int VLEN  = 512,
  localparam int OFF_W = $clog2(VLEN / 8)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [`XLEN-1:0]  vec_length,
  input  logic [`XLEN-1:0]  start_element,
  input  logic [6:0]        sew,
  input  logic [3:0]        vlmul,
  input  logic              tail_agnostic,
  input  logic              mask_agnostic,
  output logic              elem_valid,
  input  logic              elem_ready,
  output logic [`XLEN-1:0]  elem_idx,
  output logic [2:0]        elem_reg,
  output logic [OFF_W-1:0]  elem_off,
  output logic              elem_tail,
  output logic              elem_ma,
  output logic              busy,
  output logic              done,
  output logic              vstart_clr,
  output logic              cfg_err
);

  localparam int XW = `XLEN;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_TAIL = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [1:0]       state_reg,   state_next;
  logic [XW-1:0]    idx_reg,     idx_next;
  logic [2:0]       grp_reg,     grp_next;
  logic [OFF_W-1:0] off_reg,     off_next;
  logic [OFF_W-1:0] off_max_reg, off_max_next;   // elements per register - 1
  logic [XW-1:0]    vl_eff_reg,  vl_eff_next;
  logic [XW-1:0]    vlmax_reg,   vlmax_next;
  logic             vma_reg,     vma_next;
  logic             cfg_err_reg, cfg_err_next;
  logic             tail_en;        // tail issue enabled for the running instruction
  logic             tail_en_in;     // tail issue enabled for the instruction being accepted

`ifdef VEC_TAIL_FILL_EN
  logic vta_reg, vta_next;
  assign tail_en    = vta_reg;
  assign tail_en_in = tail_agnostic;
`else
  logic unused_vta;
  assign unused_vta = tail_agnostic;
  assign tail_en    = 1'b0;
  assign tail_en_in = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Instruction decode (only meaningful while idle)
  // -------------------------------------------------------------------------
  logic             sew_ok, lmul_ok;
  logic [1:0]       sew_log2;       // log2(sew/8)
  logic [1:0]       lmul_log2;
  logic [XW-1:0]    epr;            // elements per register = VLEN/sew
  logic [XW-1:0]    vlmax_dec;
  logic [XW-1:0]    vl_eff_dec;
  logic [XW-1:0]    start_idx;
  logic [2:0]       start_grp;
  logic [OFF_W-1:0] start_off;

  always_comb begin
    sew_ok    = 1'b1;
    sew_log2  = 2'd0;
    case (sew)
      7'd8:    sew_log2 = 2'd0;
      7'd16:   sew_log2 = 2'd1;
      7'd32:   sew_log2 = 2'd2;
      7'd64:   sew_log2 = 2'd3;
      default: sew_ok   = 1'b0;
    endcase

    lmul_ok   = 1'b1;
    lmul_log2 = 2'd0;
    case (vlmul)
      4'd1:    lmul_log2 = 2'd0;
      4'd2:    lmul_log2 = 2'd1;
      4'd4:    lmul_log2 = 2'd2;
      4'd8:    lmul_log2 = 2'd3;
      default: lmul_ok   = 1'b0;
    endcase

    // vlmax = VLEN*vlmul/sew, built from shifts only
    epr        = XW'(VLEN / 8) >> sew_log2;
    vlmax_dec  = epr << lmul_log2;
    vl_eff_dec = (vec_length < vlmax_dec) ? vec_length : vlmax_dec;

    // When vstart is past the body, the first issued index (if any) is the
    // first tail element.
    start_idx  = (start_element < vl_eff_dec) ? start_element : vl_eff_dec;

    // idx / epr == (idx << log2(sew/8)) >> log2(VLEN/8); start_idx < 8*epr
    // so the pre-shift value cannot overflow XLEN.
    start_grp  = 3'((start_idx << sew_log2) >> OFF_W);
    start_off  = OFF_W'(start_idx & (epr - XW'(1)));
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  logic fire;
  assign fire = elem_valid & elem_ready;

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    grp_next     = grp_reg;
    off_next     = off_reg;
    off_max_next = off_max_reg;
    vl_eff_next  = vl_eff_reg;
    vlmax_next   = vlmax_reg;
    vma_next     = vma_reg;
    cfg_err_next = cfg_err_reg;
`ifdef VEC_TAIL_FILL_EN
    vta_next     = vta_reg;
`endif

    // Element advance: the offset counter wraps at the register boundary and
    // carries into the group register, so no divide sits in the loop.
    if (fire) begin
      idx_next = idx_reg + XW'(1);
      if (off_reg == off_max_reg) begin
        off_next = '0;
        grp_next = grp_reg + 3'd1;
      end else begin
        off_next = off_reg + OFF_W'(1);
      end
    end

    case (state_reg)
      S_IDLE: begin
        if (instr_valid) begin
          idx_next     = start_idx;
          grp_next     = start_grp;
          off_next     = start_off;
          off_max_next = OFF_W'(epr - XW'(1));
          vl_eff_next  = vl_eff_dec;
          vlmax_next   = vlmax_dec;
          vma_next     = mask_agnostic;
          cfg_err_next = !(sew_ok && lmul_ok);
`ifdef VEC_TAIL_FILL_EN
          vta_next     = tail_agnostic;
`endif
          if (!(sew_ok && lmul_ok)) begin
            state_next = S_FIN;
          end else if (start_element >= vl_eff_dec) begin
            state_next = (tail_en_in && (vl_eff_dec < vlmax_dec)) ? S_TAIL : S_FIN;
          end else begin
            state_next = S_RUN;
          end
        end
      end

      S_RUN: begin
        if (fire && (idx_reg == vl_eff_reg - XW'(1))) begin
          state_next = (tail_en && (vl_eff_reg < vlmax_reg)) ? S_TAIL : S_FIN;
        end
      end

      S_TAIL: begin
        if (fire && (idx_reg == vlmax_reg - XW'(1))) begin
          state_next = S_FIN;
        end
      end

      default: begin  // S_FIN
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg   <= S_IDLE;
      idx_reg     <= '0;
      grp_reg     <= '0;
      off_reg     <= '0;
      off_max_reg <= '0;
      vl_eff_reg  <= '0;
      vlmax_reg   <= '0;
      vma_reg     <= 1'b0;
      cfg_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      grp_reg     <= grp_next;
      off_reg     <= off_next;
      off_max_reg <= off_max_next;
      vl_eff_reg  <= vl_eff_next;
      vlmax_reg   <= vlmax_next;
      vma_reg     <= vma_next;
      cfg_err_reg <= cfg_err_next;
    end
  end

`ifdef VEC_TAIL_FILL_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vta_reg <= 1'b0;
    end else begin
      vta_reg <= vta_next;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs: pure decodes of registered state, so elem_valid never depends
  // on elem_ready and everything holds during a stall.
  // -------------------------------------------------------------------------
  assign instr_ready = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign elem_valid  = (state_reg == S_RUN) || (state_reg == S_TAIL);
  assign done        = (state_reg == S_FIN);
  assign vstart_clr  = (state_reg == S_FIN);
  assign elem_idx    = idx_reg;
  assign elem_reg    = grp_reg;
  assign elem_off    = off_reg;
  assign elem_ma     = vma_reg;
  assign cfg_err     = cfg_err_reg;
`ifdef VEC_TAIL_FILL_EN
  assign elem_tail   = (state_reg == S_TAIL);
`else
  assign elem_tail   = 1'b0;
`endif

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// ---------------------------------------------------------------------------
// tb_vec_elem_sequencer
//
// Directed bench for vec_elem_sequencer (VLEN=512). Each instruction's
// expected element stream is computed by a small reference model (plain
// divide/modulo) and pushed to a queue when the instruction is driven; the
// queue is popped and compared on every element handshake. Completion
// timing, stall stability, cfg_err and mid-run reset are checked directly.
// ---------------------------------------------------------------------------
`ifndef XLEN
`define XLEN 32
`endif

module tb_vec_elem_sequencer;

  localparam int VLEN  = 512;
  localparam int XW    = `XLEN;
  localparam int OFF_W = $clog2(VLEN / 8);

  logic             clk = 1'b0;
  logic             n_rst;
  logic             instr_valid;
  logic             instr_ready;
  logic [XW-1:0]    vec_length;
  logic [XW-1:0]    start_element;
  logic [6:0]       sew;
  logic [3:0]       vlmul;
  logic             tail_agnostic;
  logic             mask_agnostic;
  logic             elem_valid;
  logic             elem_ready;
  logic [XW-1:0]    elem_idx;
  logic [2:0]       elem_reg;
  logic [OFF_W-1:0] elem_off;
  logic             elem_tail;
  logic             elem_ma;
  logic             busy;
  logic             done;
  logic             vstart_clr;
  logic             cfg_err;

  vec_elem_sequencer #(.VLEN(VLEN)) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .vec_length    (vec_length),
    .start_element (start_element),
    .sew           (sew),
    .vlmul         (vlmul),
    .tail_agnostic (tail_agnostic),
    .mask_agnostic (mask_agnostic),
    .elem_valid    (elem_valid),
    .elem_ready    (elem_ready),
    .elem_idx      (elem_idx),
    .elem_reg      (elem_reg),
    .elem_off      (elem_off),
    .elem_tail     (elem_tail),
    .elem_ma       (elem_ma),
    .busy          (busy),
    .done          (done),
    .vstart_clr    (vstart_clr),
    .cfg_err       (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XW-1:0]    idx;
    logic [2:0]       grp;
    logic [OFF_W-1:0] off;
    logic             tail;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, model its expected element stream, then consume
  // it with elem_ready following rdy_pat (bit k used on loop cycle k%32).
  task automatic run_instr(input string name, input int vl, input int vs, input int s,
                           input int lm, input logic vta, input logic vma,
                           input logic [31:0] rdy_pat);
    int            epr, vlmax, vl_eff, n, k, issued;
    bit            err, stalled;
    exp_t          e, got;
    logic [XW-1:0] pidx;
    logic [OFF_W-1:0] poff;

    err    = !(s inside {8, 16, 32, 64}) || !(lm inside {1, 2, 4, 8});
    issued = 0;
    if (!err) begin
      epr    = VLEN / s;
      vlmax  = epr * lm;
      vl_eff = (vl < vlmax) ? vl : vlmax;
      for (int i = vs; i < vl_eff; i++) begin
        e.idx = XW'(i); e.grp = 3'(i / epr); e.off = OFF_W'(i % epr); e.tail = 1'b0;
        exp_q.push_back(e);
      end
`ifdef VEC_TAIL_FILL_EN
      if (vta) begin
        for (int i = vl_eff; i < vlmax; i++) begin
          e.idx = XW'(i); e.grp = 3'(i / epr); e.off = OFF_W'(i % epr); e.tail = 1'b1;
          exp_q.push_back(e);
        end
      end
`endif
    end
    n = exp_q.size();

    @(negedge clk);
    chk({name, ":instr_ready"}, 64'(instr_ready), 64'd1);
    instr_valid   = 1'b1;
    vec_length    = XW'(vl);
    start_element = XW'(vs);
    sew           = 7'(s);
    vlmul         = 4'(lm);
    tail_agnostic = vta;
    mask_agnostic = vma;
    elem_ready    = 1'b0;
    @(negedge clk);
    instr_valid   = 1'b0;
    chk({name, ":cfg_err"}, 64'(cfg_err), 64'(err));
    chk({name, ":busy"},    64'(busy),    64'd1);

    if (n == 0) begin
      chk({name, ":done_after_accept"}, 64'(done),       64'd1);
      chk({name, ":vstart_clr"},        64'(vstart_clr), 64'd1);
      chk({name, ":no_elem"},           64'(elem_valid), 64'd0);
    end else begin
      k       = 0;
      stalled = 1'b0;
      pidx    = '0;
      poff    = '0;
      while (exp_q.size() > 0 && k < 400) begin
        if (stalled) begin
          chk({name, ":stall_idx"}, 64'(elem_idx), 64'(pidx));
          chk({name, ":stall_off"}, 64'(elem_off), 64'(poff));
        end
        chk({name, ":valid"},      64'(elem_valid), 64'd1);
        chk({name, ":early_done"}, 64'(done),       64'd0);
        elem_ready = rdy_pat[k % 32];
        if (elem_valid && elem_ready) begin
          got = exp_q.pop_front();
          issued++;
          chk({name, ":idx"},  64'(elem_idx),  64'(got.idx));
          chk({name, ":reg"},  64'(elem_reg),  64'(got.grp));
          chk({name, ":off"},  64'(elem_off),  64'(got.off));
          chk({name, ":tail"}, 64'(elem_tail), 64'(got.tail));
          chk({name, ":ma"},   64'(elem_ma),   64'(vma));
          stalled = 1'b0;
        end else begin
          stalled = elem_valid;
          pidx    = elem_idx;
          poff    = elem_off;
        end
        k++;
        @(negedge clk);
      end
      chk({name, ":drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      elem_ready = 1'b0;
      chk({name, ":done"},       64'(done),       64'd1);
      chk({name, ":vstart_clr"}, 64'(vstart_clr), 64'd1);
      chk({name, ":valid_off"},  64'(elem_valid), 64'd0);
    end

    @(negedge clk);
    chk({name, ":done_pulse"},  64'(done),        64'd0);
    chk({name, ":idle"},        64'(instr_ready), 64'd1);
    chk({name, ":cfg_sticky"},  64'(cfg_err),     64'(err));
    $display("txn %s: vl=%0d vstart=%0d sew=%0d lmul=%0d vta=%0d issued=%0d expected=%0d",
             name, vl, vs, s, lm, vta, issued, n);
  endtask

  initial begin
    n_rst         = 1'b0;
    instr_valid   = 1'b0;
    vec_length    = '0;
    start_element = '0;
    sew           = '0;
    vlmul         = '0;
    tail_agnostic = 1'b0;
    mask_agnostic = 1'b0;
    elem_ready    = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst:instr_ready", 64'(instr_ready), 64'd1);
    chk("rst:elem_valid",  64'(elem_valid),  64'd0);
    chk("rst:busy",        64'(busy),        64'd0);
    chk("rst:done",        64'(done),        64'd0);
    chk("rst:vstart_clr",  64'(vstart_clr),  64'd0);
    chk("rst:cfg_err",     64'(cfg_err),     64'd0);
    chk("rst:elem_idx",    64'(elem_idx),    64'd0);
    @(negedge clk);
    n_rst = 1'b1;

    run_instr("basic",      10,   0, 32, 1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    run_instr("wrap",      100,  60,  8, 2, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_instr("clamp",      40,   0, 32, 1, 1'b1, 1'b1, 32'hFFFF_FFFF);
    run_instr("stall",      70,   3, 16, 4, 1'b0, 1'b1, 32'h9999_9999);
    run_instr("sew_rsv",    10,   0,  0, 1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_instr("lmul_bad",   10,   0,  8, 3, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_instr("vs_past",     8,  12, 32, 1, 1'b0, 1'b0, 32'hFFFF_FFFF);
    run_instr("vs_past_ta",  8,  12, 32, 1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_instr("tail_vta1",   5,   0, 64, 1, 1'b1, 1'b0, 32'hFFFF_FFFF);
    run_instr("tail_vta0",   5,   0, 64, 1, 1'b0, 1'b1, 32'hFFFF_FFFF);

    // Reset in the middle of RUN aborts without done
    @(negedge clk);
    instr_valid   = 1'b1;
    vec_length    = XW'(20);
    start_element = '0;
    sew           = 7'd32;
    vlmul         = 4'd1;
    tail_agnostic = 1'b0;
    mask_agnostic = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    elem_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst:busy_before", 64'(busy),     64'd1);
    chk("midrst:idx_before",  64'(elem_idx), 64'd3);
    #2 n_rst = 1'b0;
    #1;
    chk("midrst:instr_ready", 64'(instr_ready), 64'd1);
    chk("midrst:elem_valid",  64'(elem_valid),  64'd0);
    chk("midrst:busy",        64'(busy),        64'd0);
    chk("midrst:done",        64'(done),        64'd0);
    chk("midrst:vstart_clr",  64'(vstart_clr),  64'd0);
    chk("midrst:elem_idx",    64'(elem_idx),    64'd0);
    chk("midrst:elem_ma",     64'(elem_ma),     64'd0);
    repeat (2) @(negedge clk);
    n_rst      = 1'b1;
    elem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst:no_done", 64'(done), 64'd0);
    end
    $display("txn midrst: reset asserted after 3 elements");

    run_instr("after_rst",   4,   1, 16, 1, 1'b0, 1'b0, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
